sync_ram: RTL

SYNC_RAM -- requirements
Module: sync_ram

---
 rtl/sync_ram_pkg.sv | 15 +
 rtl/sync_ram_clear_seq.sv | 54 +++++
 rtl/sync_ram.sv | 97 +++++++++
 3 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types and default parameter values for the sync_ram block.
package sync_ram_pkg;

    // Sweep state: CLEAR zero-fills the array, READY serves accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_TAP_ADDR       = 'h30;
    localparam bit DEF_CLEAR_ON_RESET = 1'b1;

endpackage : sync_ram_pkg

// File: rtl/sync_ram_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word address once, one per
// cycle, and reports busy while the sweep is in progress.
module sync_ram_clear_seq
    import sync_ram_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              clr_we_o
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    state_e          state_q;
    logic [ADDR_W:0] cnt_q;
    logic [ADDR_W:0] cnt_d;
    logic            busy_q;

    // The extra MSB of the counter marks "every address written", so the
    // sweep stops without ever wrapping back to address 0.
    assign cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    // Sweep FSM: advance one address per cycle, drop busy on the edge that
    // writes the last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_d;
                    if (cnt_d[ADDR_W]) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule : sync_ram_clear_seq

// File: rtl/sync_ram.sv
// Single-port word RAM with byte enables, registered write-first read,
// optional zero-fill after reset and a combinational tap on one word.
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TAP_ADDR       = DEF_TAP_ADDR,
    parameter bit CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   q,
    output logic                q_valid,
    output logic                busy,
    output logic [DATA_W-1:0]   test
);

    localparam int              NB      = DATA_W / 8;
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TAP_ADDR);

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
        $error("sync_ram: DATA_W must be a non-zero multiple of 8");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rdata_q;
    logic              valid_q;

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic              wr_en;
    logic              rd_en;

    sync_ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (clr_busy),
        .clr_addr_o (clr_addr),
        .clr_we_o   (clr_we)
    );

    // While sweeping, the user port is fully disconnected from the array.
    assign wr_en = ~clr_busy & cs & we;
    assign rd_en = ~clr_busy & cs & re;

    assign old_word = mem_q[addr];

    // Byte merge: enabled lanes take new data, the rest keep the stored byte.
    // The same merged word feeds the read register, giving write-first reads.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = be[gi] ? data[8*gi +: 8] : old_word[8*gi +: 8];
    end

    // Storage write port: sweep zeroes take priority, never reset directly.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[addr] <= merged_word;
        end
    end

    // Read register: loads on a qualified read, otherwise holds; valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= we ? merged_word : old_word;
            end
        end
    end

    assign q       = rdata_q;
    assign q_valid = valid_q;
    assign busy    = clr_busy;
    assign test    = mem_q[TAP_IDX];

endmodule : sync_ram
